vga_timing_gen: RTL
===================

Name: vga_timing_gen

Overview:
- Display-side timing master for the 640x480 video path.
- Generates the raster coordinates and strobes that the pixel-producing blocks (blob analyzer, line buffers) consume: vid_hpos, vid_vpos, vid_active_pix, vid_preload_line.
- Takes back their vid_data_out pixel stream.
- Emits DVI/VGA-ready RGB with hsync/vsync/de, delayed so that sync and DE line up with the producers' pipeline latency.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync pulse width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch
- SYNC_POL, 0, sync active level (0 = active-low)
- PIPE_LAT, 3, clocks from vid_hpos/vid_vpos to the matching vid_data_in pixel (1..7)

Ports:
- app_clk  in  1  pixel clock, same as vid_clk
- app_rst  in  1  synchronous active-high reset
- vid_ce  in  1  pixel clock enable; counters and delay line advance only when high
- vid_hpos  out  11  horizontal count, 0..H_TOTAL-1 (H_TOTAL = 800 at defaults)
- vid_vpos  out  11  vertical count, 0..V_TOTAL-1 (V_TOTAL = 525 at defaults)
- vid_active_pix  out  1  high when hpos<H_ACTIVE and vpos<V_ACTIVE
- vid_preload_line  out  1  one-enabled-cycle pulse requesting the next line's data
- vid_frame_start  out  1  one-enabled-cycle pulse at hpos=0, vpos=0
- vid_data_in  in  24  RGB from the producer, valid PIPE_LAT enabled cycles after the coordinates
- dvi_rgb  out  24  output pixel; zero outside DE
- dvi_hsync  out  1  delayed hsync
- dvi_vsync  out  1  delayed vsync
- dvi_de  out  1  delayed data enable

Behaviour:
- Reset (app_clk edge with app_rst=1, regardless of vid_ce):
  - hpos=0, vpos=0, active_pix=0, preload=0, frame_start=0.
  - Delay line cleared to the inactive state.
  - dvi_rgb=0, dvi_de=0, dvi_hsync=dvi_vsync=~SYNC_POL (1 at defaults).
- First enabled cycle after reset presents hpos=0, vpos=0.
- Reset mid-frame aborts immediately. No partial sync pulse is extended; the raster restarts at (0,0).
- Counters (registered outputs), advancing on each vid_ce=1 cycle:
  - hpos increments; at H_TOTAL-1 it wraps to 0 and vpos increments.
  - vpos wraps from V_TOTAL-1 to 0 on the same cycle hpos wraps.
  - When vid_ce=0, all registers hold and pulses are 0 that cycle. Pulses last exactly one enabled cycle.
- Raw strobes are combinational from the current counters:
  - hs_raw: H_ACTIVE+H_FP <= hpos < H_ACTIVE+H_FP+H_SYNC (656..751).
  - vs_raw: V_ACTIVE+V_FP <= vpos < V_ACTIVE+V_FP+V_SYNC (490..491).
  - vid_active_pix = de_raw.
- vid_preload_line:
  - Pulses when hpos==H_ACTIVE and the next line, (vpos+1) mod V_TOTAL, is below V_ACTIVE.
  - This is line 524 (-> 0) and lines 0..478. No pulse on lines 479..523.
- vid_frame_start: pulses while hpos==0 && vpos==0.
- Delay line:
  - {hs_raw, vs_raw, de_raw} is shifted through a PIPE_LAT-deep shift register, advancing only on vid_ce.
  - Outputs take the tap at depth PIPE_LAT:
    - dvi_de = tapped de;
    - dvi_hsync = tapped hs XOR ~SYNC_POL;
    - dvi_vsync likewise;
    - dvi_rgb = tapped de ? vid_data_in : 0.
  - vid_data_in is sampled on the same edge as the tap, so total sync-to-pixel alignment is exact.
  - The output registers update only on vid_ce.
- Widths: all comparisons use 11-bit unsigned. H_TOTAL and V_TOTAL must be <= 2047. Parameter sums are computed as localparams.

Test Plan:
- Reset release, vid_ce=1: first enabled cycle gives hpos=0, vpos=0, active_pix=1, frame_start=1. Nothing else: dvi_de=0, dvi_hsync=1, dvi_rgb=0 until 3 cycles later, when dvi_de=1.
- Horizontal timing: over one line, active_pix is high 640 cycles. hs_raw is low for hpos 656..751 (96 cycles). dvi_hsync is low 3 cycles later. Line period is 800.
- Frame timing: vpos wraps 524 -> 0 on the cycle hpos wraps 799 -> 0. dvi_vsync is low for 2x800 clocks starting at vpos=490. frame_start pulses once per 420000 enabled cycles. preload_line has 480 pulses per frame; none on lines 479..523.
- Pixel alignment: drive vid_data_in = {13'b0, hpos delayed by 3} -> dvi_rgb[10:0] equals 0 on the first DE cycle and 639 on the last. dvi_rgb=0 while dvi_de=0 even with vid_data_in=24'hFFFFFF.
- Clock enable: vid_ce toggled 1,0,1,0 -> hpos advances every other cycle. Pulses never last 2 cycles. Delay alignment is preserved in enabled cycles.
- Reset mid-frame: assert app_rst at hpos=700, vpos=491 (during vsync) -> next cycle hpos=0, vpos=0, dvi_vsync=1, dvi_de=0. The raster resumes normally.

Source files
------------

// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: raster coordinates and strobes to the pixel producers, returned pixel
// stream, and the DVI-side RGB/sync bundle.
interface vga_timing_gen_if;
    logic        vid_ce;
    logic [10:0] vid_hpos;
    logic [10:0] vid_vpos;
    logic        vid_active_pix;
    logic        vid_preload_line;
    logic        vid_frame_start;
    logic [23:0] vid_data_in;
    logic [23:0] dvi_rgb;
    logic        dvi_hsync;
    logic        dvi_vsync;
    logic        dvi_de;
    modport master (
        input  vid_ce, vid_data_in,
        output vid_hpos, vid_vpos, vid_active_pix, vid_preload_line, vid_frame_start,
        output dvi_rgb, dvi_hsync, dvi_vsync, dvi_de
    );
    modport slave (
        output vid_ce, vid_data_in,
        input  vid_hpos, vid_vpos, vid_active_pix, vid_preload_line, vid_frame_start,
        input  dvi_rgb, dvi_hsync, dvi_vsync, dvi_de
    );
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster counters and strobes for the producers, plus sync/DE delayed by
// PIPE_LAT enabled clocks so they line up with the returned pixel stream.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int SYNC_POL = 0,
    parameter int PIPE_LAT = 3
) (
    input logic              app_clk,
    input logic              app_rst,
    vga_timing_gen_if.master vif
);
    localparam logic [10:0] HA  = 11'(H_ACTIVE);
    localparam logic [10:0] HS0 = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS1 = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] HT1 = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [10:0] VA  = 11'(V_ACTIVE);
    localparam logic [10:0] VS0 = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS1 = 11'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [10:0] VT1 = 11'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic        IDLE_LVL = ~1'(SYNC_POL);
    logic [10:0]               hpos, vpos, vnext;
    logic                      hs_raw, vs_raw, de_raw, run;
    logic [PIPE_LAT-1:0][2:0]  dly;
    logic [2:0]                tap;
    always_comb begin
        hs_raw = hpos >= HS0 && hpos < HS1;
        vs_raw = vpos >= VS0 && vpos < VS1;
        de_raw = hpos < HA && vpos < VA;
        vnext  = vpos == VT1 ? '0 : vpos + 11'd1;
        run    = vif.vid_ce && !app_rst;
        tap    = dly[PIPE_LAT-1];
    end
    // Stage 0 holds the strobes of the current coordinates; the last stage is the output.
    always_ff @(posedge app_clk)
        if (app_rst) begin
            hpos <= '0;
            vpos <= '0;
            dly  <= '0;
        end else if (vif.vid_ce) begin
            hpos <= hpos == HT1 ? '0 : hpos + 11'd1;
            vpos <= hpos == HT1 ? vnext : vpos;
            dly[0] <= {hs_raw, vs_raw, de_raw};
            for (int i = 1; i < PIPE_LAT; i++) dly[i] <= dly[i-1];
        end
    assign vif.vid_hpos         = hpos;
    assign vif.vid_vpos         = vpos;
    assign vif.vid_active_pix   = de_raw && !app_rst;
    assign vif.vid_preload_line = run && hpos == HA && vnext < VA;
    assign vif.vid_frame_start  = run && hpos == '0 && vpos == '0;
    // Pixel arrives on the same cycle its delayed DE does, so it is gated, not re-registered.
    assign vif.dvi_de    = tap[0];
    assign vif.dvi_vsync = tap[1] ^ IDLE_LVL;
    assign vif.dvi_hsync = tap[2] ^ IDLE_LVL;
    assign vif.dvi_rgb   = tap[0] ? vif.vid_data_in : '0;
endmodule
